// File: rtl/count_up_stopwatch_pkg.sv
// Shared types and constants for the count-up stopwatch: FSM encoding,
// BCD limits and the packed hh:mm:ss.cc time record.
package count_up_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [7:0] BCD_MAX_59 = 8'h59;
  localparam logic [7:0] BCD_MAX_99 = 8'h99;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [7:0] centi;
  } time_t;

  // Two-digit packed-BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = '0;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/count_up_stopwatch_bcd_stage.sv
// Two-digit BCD counter stage; carry flags an increment arriving at MAX_BCD.
module stopwatch_bcd_stage
  import count_up_stopwatch_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = BCD_MAX_99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  input  logic       freeze,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] count_q;

  // freeze blocks the update so a saturating chain holds instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && !freeze) begin
      count_q <= bcd_inc(count_q, MAX_BCD);
    end
  end

  assign value = count_q;
  assign carry = inc && (count_q == MAX_BCD);

endmodule

// File: rtl/count_up_stopwatch.sv
// Count-up stopwatch: prescaled BCD cascade with run/pause, lap freeze,
// clear and saturation at HOUR_MAX_BCD:59:59.99.
module count_up_stopwatch
  import count_up_stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_CS = 10,
  parameter logic [7:0]  HOUR_MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clock_en,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [7:0] hour_out_bcd,
  output logic [7:0] minute_out_bcd,
  output logic [7:0] second_out_bcd,
  output logic [7:0] centi_out_bcd,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int unsigned PRESC_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CS - 1);

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic               lap_q;
  logic               ovf_q;
  logic               run_q;
  time_t              snap;
  time_t              live;
  time_t              disp;

  logic ev_clear, ev_ss, ev_lap;
  logic count_en, tick, sat;
  logic centi_carry, second_carry, minute_carry;
  logic [7:0] hour_v, minute_v, second_v, centi_v;

  // Priority clear > start_stop > lap; an event only counts where it is valid.
  assign ev_clear = clear && ((state == PAUSE) || (state == HALT));
  assign ev_ss    = start_stop && !ev_clear && (state != HALT);
  assign ev_lap   = lap && !ev_clear && !ev_ss && ((state == RUN) || (state == PAUSE));

  assign count_en = (state == RUN) && clock_en && !ev_ss;
  assign tick     = count_en && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ev_clear) begin
      presc <= '0;
    end else if (count_en) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  stopwatch_bcd_stage #(.MAX_BCD(BCD_MAX_99)) u_centi (
    .clk(clk), .rst_n(rst_n), .clear(ev_clear), .inc(tick), .freeze(sat),
    .value(centi_v), .carry(centi_carry)
  );

  stopwatch_bcd_stage #(.MAX_BCD(BCD_MAX_59)) u_second (
    .clk(clk), .rst_n(rst_n), .clear(ev_clear), .inc(centi_carry), .freeze(sat),
    .value(second_v), .carry(second_carry)
  );

  stopwatch_bcd_stage #(.MAX_BCD(BCD_MAX_59)) u_minute (
    .clk(clk), .rst_n(rst_n), .clear(ev_clear), .inc(second_carry), .freeze(sat),
    .value(minute_v), .carry(minute_carry)
  );

  // Hour carry only fires at full scale, so it doubles as the saturation detect.
  stopwatch_bcd_stage #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
    .clk(clk), .rst_n(rst_n), .clear(ev_clear), .inc(minute_carry), .freeze(sat),
    .value(hour_v), .carry(sat)
  );

  assign live = {hour_v, minute_v, second_v, centi_v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run_q <= 1'b0;
      lap_q <= 1'b0;
      ovf_q <= 1'b0;
      snap  <= '0;
    end else begin
      if (ev_clear) begin
        state <= IDLE;
        run_q <= 1'b0;
        lap_q <= 1'b0;
        ovf_q <= 1'b0;
        snap  <= '0;
      end else if (ev_ss) begin
        state <= (state == RUN) ? PAUSE : RUN;
        run_q <= (state != RUN);
      end else if (ev_lap) begin
        if ((state == RUN) && !lap_q) begin
          snap  <= live;
          lap_q <= 1'b1;
        end else begin
          lap_q <= 1'b0;
        end
      end
      if (sat) begin
        state <= HALT;
        run_q <= 1'b0;
        ovf_q <= 1'b1;
      end
    end
  end

  assign disp           = lap_q ? snap : live;
  assign hour_out_bcd   = disp.hour;
  assign minute_out_bcd = disp.minute;
  assign second_out_bcd = disp.second;
  assign centi_out_bcd  = disp.centi;
  assign running        = run_q;
  assign lap_active     = lap_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/count_up_stopwatch.md
Name: count_up_stopwatch

Overview:
- Stopwatch companion to the count-down timer, counting up from 00:00:00.00 with centisecond resolution.
- Sits in the same 1 kHz clock domain and produces packed-BCD hour/minute/second/centisecond for the display mux.
- Supports start/stop toggle, lap (split) freeze of the display, and clear.
- Counts directly in BCD, so no divide/modulo or bin2bcd stages are needed.

Parameters:
TICKS_PER_CS, 10, enabled clk cycles per centisecond (1 kHz clk gives 10)
HOUR_MAX_BCD, 8'h99, saturation hour value (packed BCD)

Ports:
clk  input  1  system clock, 1 kHz
rst_n  input  1  asynchronous, active-low reset
clock_en  input  1  count enable qualifier; one enabled cycle = one tick
start_stop  input  1  single-cycle pulse: toggles run/pause
lap  input  1  single-cycle pulse: freezes or releases the displayed split
clear  input  1  single-cycle pulse: zeroes the count (ignored while running)
hour_out_bcd  output  8  displayed hours, BCD 00..HOUR_MAX_BCD
minute_out_bcd  output  8  displayed minutes, BCD 00..59
second_out_bcd  output  8  displayed seconds, BCD 00..59
centi_out_bcd  output  8  displayed centiseconds, BCD 00..99
running  output  1  high in RUN
lap_active  output  1  high while the display shows the frozen split
overflow  output  1  sticky; high in HALT

Behaviour:
- Reset is asynchronous, active-low, on clk. It clears all count, snapshot and prescaler registers and sets the state to IDLE. Outputs after reset: all BCD outputs 8'h00, running=0, lap_active=0, overflow=0.
- State machine: IDLE, RUN, PAUSE, HALT.
- Event priority within one cycle: clear > start_stop > lap. Only the highest-priority valid event is acted on; lower-priority events in that cycle are dropped.
- IDLE:
  - start_stop → RUN.
  - clear: no-op, count stays zero.
  - lap: ignored.
- RUN:
  - start_stop → PAUSE.
  - clear: ignored.
  - lap with lap_active=0: copy the live count into the snapshot and set lap_active=1.
  - lap with lap_active=1: set lap_active=0, so the display returns to live.
- PAUSE:
  - start_stop → RUN.
  - clear → IDLE. Zeroes count, snapshot and prescaler; lap_active=0.
  - lap: sets lap_active=0 (releases the freeze), no snapshot taken.
- HALT:
  - clear → IDLE and overflow=0.
  - start_stop and lap: ignored.
- Counting happens only when state==RUN and clock_en=1.
  - Prescaler counts 0..TICKS_PER_CS-1. On its terminal count it wraps to 0 and increments the centiseconds.
  - The prescaler is preserved across PAUSE and zeroed only on clear or reset.
- BCD cascade, one tick per carry:
  - Centiseconds 00..99 carries into seconds.
  - Seconds 00..59 carries into minutes.
  - Minutes 00..59 carries into hours.
  - Each digit rolls 9→0 with carry to the tens digit.
  - Tens digit of seconds and minutes wraps at 5→0; tens digit of centiseconds wraps at 9→0.
- Saturation: a centisecond increment requested at HOUR_MAX_BCD:59:59.99 does not wrap.
  - The count holds at max, state → HALT, overflow=1 and running=0 from the next cycle.
  - lap_active is left unchanged.
- A start_stop pulse that enters RUN does not count in the same cycle. Counting begins on the following enabled cycle.
- A start_stop pulse that leaves RUN suppresses the count in that cycle.
- Display mux (combinational on registered values):
  - lap_active=1: outputs show the snapshot.
  - lap_active=0: outputs show the live count.
  - The live display reflects an increment on the same edge that updates the count, so there is zero added latency.
- Snapshot capture in a counting cycle takes the pre-increment value, i.e. the register contents before the edge.
- Inputs are assumed synchronous, single-cycle pulses; debounce and edge detection are done upstream.
- Reset asserted mid-run aborts immediately. No state persists.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, HALT=2'd3).
  - BCD limit constants: 8'h59 for minutes/seconds, 8'h99 for centiseconds.
  - A packed time-record typedef {hour, minute, second, centi} of 4×8 bits, used for both the live and snapshot registers.
- One sub-module, stopwatch_bcd_stage:
  - A two-digit BCD counter with an inc input, a parameterised max value, a synchronous clear, and a carry output asserted when inc arrives at max.
  - Instantiated four times: centi, second, minute, hour.
  - The hour instance's carry is the overflow detect.

Test Plan:
1. Reset, then start_stop, then 1000 enabled cycles → outputs 00:00:01.00, running=1, overflow=0.
2. Run 12 enabled cycles, pulse start_stop, apply 50 further enabled cycles, pulse start_stop again, then 8 enabled cycles → count reads 00:00:00.02 (prescaler preserved across pause); state RUN.
3. Run to 00:00:05.00, pulse lap → display frozen at 00:00:05.00 and lap_active=1 while the live count continues. After 2000 more cycles, pulse lap → display 00:00:07.00, lap_active=0.
4. Force the count to 00:00:59.99 with prescaler 9, apply 1 enabled cycle → 00:01:00.00 (ripple through centi/second/minute). Repeat at 00:59:59.99 → 01:00:00.00.
5. Force the count to 99:59:59.99 with prescaler 9, apply 1 enabled cycle → count holds 99:59:59.99, overflow=1, running=0. Pulse start_stop → no change. Pulse clear → 00:00:00.00, overflow=0, state IDLE.
6. In PAUSE, assert clear, start_stop and lap in the same cycle → clear wins: state IDLE, count zero. Pulse clear during RUN → ignored. Assert rst_n low mid-count → all outputs 0 asynchronously.
